fp_adder_seq: RTL and testbench

//  Multi-cycle IEEE-754 binary64 adder. Companion to the combinational double subtractor in the FPU.

---
 rtl/fp_adder_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_fp_adder_seq.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_seq.sv
`default_nettype none
//==============================================================================
// Module   : fp_adder_seq
// Brief    : Multi-cycle binary64 adder (RNE), left normalisation one bit/cycle.
//            Define FP_SUB_EN to add the `op` input (op=1 computes A-B).
// Revision : 1.0  initial release
//==============================================================================
module fp_adder_seq #(
    parameter int W_EXP  = 11,
    parameter int W_MANT = 52,
    parameter int BIAS   = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] A,
    input  logic [63:0] B,
`ifdef FP_SUB_EN
    input  logic        op,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result
);
    localparam int c_WW = W_MANT + 5;
    localparam int c_WX = W_EXP + 1;
    localparam int c_SB = W_EXP + W_MANT;
    localparam logic [c_WX-1:0] c_EXP_INF = c_WX'(2 * BIAS + 1);
    localparam logic [c_WX-1:0] c_SH_MAX  = c_WX'(c_WW - 1);
    localparam logic [63:0]     c_QNAN    = 64'h7FF8000000000000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [63:0]     r_a, r_b, w_a_nxt, w_b_nxt;
    logic            r_sign, w_sign_nxt, r_sub, w_sub_nxt;
    logic [c_WX-1:0] r_exp, w_exp_nxt;
    logic [c_WW-1:0] r_mant_l, r_mant_s, r_mant;
    logic [c_WW-1:0] w_mant_l_nxt, w_mant_s_nxt, w_mant_nxt;
    logic [63:0]     r_result, w_result_nxt;
    logic            r_out_valid, w_out_valid_nxt;

    logic w_b_flip;
`ifdef FP_SUB_EN
    assign w_b_flip = op;
`else
    assign w_b_flip = 1'b0;
`endif

    logic [63:0] w_b_in;
    assign w_b_in = {B[c_SB] ^ w_b_flip, B[c_SB-1:0]};

    // Operand classification from the registered operands
    logic [W_EXP-1:0]  w_ea, w_eb;
    logic [W_MANT-1:0] w_fa, w_fb;
    logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    assign w_ea     = r_a[c_SB-1:W_MANT];
    assign w_eb     = r_b[c_SB-1:W_MANT];
    assign w_fa     = r_a[W_MANT-1:0];
    assign w_fb     = r_b[W_MANT-1:0];
    assign w_a_nan  = (&w_ea) & (|w_fa);
    assign w_b_nan  = (&w_eb) & (|w_fb);
    assign w_a_inf  = (&w_ea) & ~(|w_fa);
    assign w_b_inf  = (&w_eb) & ~(|w_fb);
    assign w_a_zero = ~(|w_ea);
    assign w_b_zero = ~(|w_eb);

    logic        w_special;
    logic [63:0] w_spec_res;
    always_comb begin
        w_special  = 1'b1;
        w_spec_res = 64'h0;
        if (w_a_nan || w_b_nan)       w_spec_res = c_QNAN;
        else if (w_a_inf && w_b_inf)  w_spec_res = (r_a[c_SB] != r_b[c_SB]) ? c_QNAN : r_a;
        else if (w_a_inf)             w_spec_res = r_a;
        else if (w_b_inf)             w_spec_res = r_b;
        else if (w_a_zero && w_b_zero)
            w_spec_res = (r_a[c_SB] & r_b[c_SB]) ? 64'h8000000000000000 : 64'h0;
        else if (w_a_zero)            w_spec_res = r_b;
        else if (w_b_zero)            w_spec_res = r_a;
        else                          w_special  = 1'b0;
    end

    // Alignment: larger magnitude first, smaller shifted right with sticky
    logic              w_a_ge;
    logic [W_EXP-1:0]  w_e_big, w_e_sml, w_diff;
    logic [W_MANT-1:0] w_f_big, w_f_sml;
    logic [c_WX-1:0]   w_sh;
    logic [c_WW-1:0]   w_sml_m, w_sml_sh, w_mask;
    logic              w_sticky;
    assign w_a_ge   = (r_a[c_SB-1:0] >= r_b[c_SB-1:0]);
    assign w_e_big  = w_a_ge ? w_ea : w_eb;
    assign w_e_sml  = w_a_ge ? w_eb : w_ea;
    assign w_f_big  = w_a_ge ? w_fa : w_fb;
    assign w_f_sml  = w_a_ge ? w_fb : w_fa;
    assign w_diff   = w_e_big - w_e_sml;
    assign w_sh     = ({1'b0, w_diff} > c_SH_MAX) ? c_SH_MAX : {1'b0, w_diff};
    assign w_sml_m  = {2'b01, w_f_sml, 3'b000};
    assign w_sml_sh = w_sml_m >> w_sh;
    assign w_mask   = (c_WW'(1) << w_sh) - c_WW'(1);
    assign w_sticky = |(w_sml_m & w_mask);

    // Round-to-nearest-even; a fraction overflow means the significand became 10.0
    logic                w_round_up, w_rcarry;
    logic [W_MANT-1:0]   w_rfrac;
    logic [c_WX-1:0]     w_rexp;
    assign w_round_up          = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    assign {w_rcarry, w_rfrac} = {1'b0, r_mant[c_WW-3:3]} + (W_MANT + 1)'(w_round_up);
    assign w_rexp              = r_exp + c_WX'(w_rcarry);

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_sign_nxt      = r_sign;
        w_sub_nxt       = r_sub;
        w_exp_nxt       = r_exp;
        w_mant_l_nxt    = r_mant_l;
        w_mant_s_nxt    = r_mant_s;
        w_mant_nxt      = r_mant;
        w_result_nxt    = r_result;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_nxt     = A;
                    w_b_nxt     = w_b_in;
                    w_state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (w_special) begin
                    w_result_nxt    = w_spec_res;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_mant_l_nxt = {2'b01, w_f_big, 3'b000};
                    w_mant_s_nxt = {w_sml_sh[c_WW-1:1], w_sml_sh[0] | w_sticky};
                    w_exp_nxt    = {1'b0, w_e_big};
                    w_sign_nxt   = w_a_ge ? r_a[c_SB] : r_b[c_SB];
                    w_sub_nxt    = r_a[c_SB] ^ r_b[c_SB];
                    w_state_nxt  = S_ADD;
                end
            end
            S_ADD: begin
                w_mant_nxt  = r_sub ? (r_mant_l - r_mant_s) : (r_mant_l + r_mant_s);
                w_state_nxt = S_NORM;
            end
            S_NORM: begin
                if (r_mant == '0) begin
                    w_result_nxt    = 64'h0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else if (r_mant[c_WW-1]) begin
                    w_mant_nxt  = {1'b0, r_mant[c_WW-1:2], r_mant[1] | r_mant[0]};
                    w_exp_nxt   = r_exp + c_WX'(1);
                    w_state_nxt = S_ROUND;
                end else if (r_mant[c_WW-2]) begin
                    w_state_nxt = S_ROUND;
                end else if (r_exp == c_WX'(1)) begin
                    // Would need a denormal: flush to +0
                    w_result_nxt    = 64'h0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_mant_nxt = r_mant << 1;
                    w_exp_nxt  = r_exp - c_WX'(1);
                    if (r_mant[c_WW-3]) w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                if (w_rexp >= c_EXP_INF)
                    w_result_nxt = {r_sign, {W_EXP{1'b1}}, {W_MANT{1'b0}}};
                else
                    w_result_nxt = {r_sign, w_rexp[W_EXP-1:0], w_rfrac};
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sign      <= 1'b0;
            r_sub       <= 1'b0;
            r_exp       <= '0;
            r_mant_l    <= '0;
            r_mant_s    <= '0;
            r_mant      <= '0;
            r_result    <= 64'h0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_sign      <= w_sign_nxt;
            r_sub       <= w_sub_nxt;
            r_exp       <= w_exp_nxt;
            r_mant_l    <= w_mant_l_nxt;
            r_mant_s    <= w_mant_s_nxt;
            r_mant      <= w_mant_nxt;
            r_result    <= w_result_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_seq.sv
`default_nettype none
//==============================================================================
// Module   : tb_fp_adder_seq
// Brief    : Self-checking bench for fp_adder_seq against a real-arithmetic model.
// Revision : 1.0  initial release
//==============================================================================
module tb_fp_adder_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
`ifdef FP_SUB_EN
    logic        op;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    fp_adder_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
`ifdef FP_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: IEEE double add of the simulator, plus the block's special/flush rules
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
        logic a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_z, b_z;
        logic [63:0] r;
        a_max = (a[62:52] == 11'h7FF);
        b_max = (b[62:52] == 11'h7FF);
        a_nan = a_max && (a[51:0] != 0);
        b_nan = b_max && (b[51:0] != 0);
        a_inf = a_max && (a[51:0] == 0);
        b_inf = b_max && (b[51:0] == 0);
        a_z   = (a[62:52] == 0);
        b_z   = (b[62:52] == 0);
        if (a_nan || b_nan) return QNAN;
        if (a_inf && b_inf) return (a[63] != b[63]) ? QNAN : a;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a_z && b_z) return (a[63] && b[63]) ? 64'h8000000000000000 : 64'h0;
        if (a_z) return b;
        if (b_z) return a;
        r = $realtobits($bitstoreal(a) + $bitstoreal(b));
        if (r[62:52] == 0) r = 64'h0;
        return r;
    endfunction

    function automatic logic [51:0] rfrac();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[51:0];
    endfunction

    function automatic logic [63:0] mk(input logic s, input int e, input logic [51:0] f);
        logic [10:0] e11;
        e11 = e[10:0];
        return {s, e11, f};
    endfunction

    // One transaction; lat = edges after the accept edge until out_valid is seen
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic opv,
                         input logic hold, output logic [63:0] res, output int lat,
                         output bit tmo);
        int guard;
        tmo   = 0;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) tmo = 1;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = !hold;
`ifdef FP_SUB_EN
        op = opv;
`else
        if (opv) tmo = 1;
`endif
        @(posedge clk);
        #1;
        // Keep in_valid up with junk while busy; it must be ignored
        A   = {$urandom, $urandom};
        B   = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) tmo = 1;
        res = result;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 64'h0;
        B         = 64'h0;
`ifdef FP_SUB_EN
        op        = 1'b0;
`endif
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (result !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_result got %h want 0", result);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [63:0] ta [4];
        logic [63:0] tb [4];
        logic [63:0] te [4];
        int          tl [4];
        logic [63:0] res;
        int          lat;
        bit          tmo;
        ta = '{64'h3FF0000000000000, 64'h3FF8000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000};
        tb = '{64'h4000000000000000, 64'hBFF8000000000000, 64'h3CA0000000000000, 64'hBFEFFFFFFFFFFFFF};
        te = '{64'h4008000000000000, 64'h0000000000000000, 64'h3FF0000000000000, 64'h3CA0000000000000};
        tl = '{4, -1, -1, 56};
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], 1'b0, 1'b0, res, lat, tmo);
            n_checks++;
            if (tmo || res !== te[i]) begin
                n_errors++;
                $display("FAIL directed%0d_result got %h want %h timeout=%0d", i + 1, res, te[i], tmo);
            end
            if (tl[i] >= 0) begin
                n_checks++;
                if (lat != tl[i]) begin
                    n_errors++;
                    $display("FAIL directed%0d_latency got %0d want %0d", i + 1, lat, tl[i]);
                end
            end
        end
    endtask

    task automatic test_specials();
        logic [63:0] sa [8];
        logic [63:0] sb [8];
        logic [63:0] se [8];
        logic [63:0] res;
        int          lat;
        bit          tmo;
        sa = '{64'h7FF0000000000001, 64'h7FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000,
               64'h8000000000000000, 64'h8000000000000000, 64'h0000000000000123, 64'h4000000000000000};
        sb = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'hFFF0000000000000, 64'hC000000000000000,
               64'h8000000000000000, 64'h0000000000000000, 64'h8000000000000456, 64'h800FFFFFFFFFFFFF};
        se = '{QNAN, 64'h7FF0000000000000, 64'hFFF0000000000000, 64'hC000000000000000,
               64'h8000000000000000, 64'h0000000000000000, 64'h0000000000000000, 64'h4000000000000000};
        for (int i = 0; i < 8; i++) begin
            do_op(sa[i], sb[i], 1'b0, 1'b0, res, lat, tmo);
            n_checks++;
            if (tmo || res !== se[i] || lat != 1) begin
                n_errors++;
                $display("FAIL special%0d got %h lat %0d want %h lat 1", i, res, lat, se[i]);
            end
        end
        // +inf + -inf, then stall the consumer
        do_op(64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, 1'b1, res, lat, tmo);
        n_checks++;
        if (tmo || res !== QNAN || lat != 1) begin
            n_errors++;
            $display("FAIL inf_minus_inf got %h lat %0d want %h lat 1", res, lat, QNAN);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            A        = 64'h3FF0000000000000;
            B        = 64'h3FF0000000000000;
            @(posedge clk);
            #1;
            n_checks++;
            if (result !== QNAN || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL hold_cycle%0d result %h in_ready %b out_valid %b want %h 0 1",
                         c, result, in_ready, out_valid, QNAN);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_release out_valid %b in_ready %b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        int          lat;
        bit          tmo;
        do_op(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 1'b0, res, lat, tmo);
        @(negedge clk);
        A         = 64'h3FF0000000000000;
        B         = 64'hBFEFFFFFFFFFFFFF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (result !== 64'h0) begin
            n_errors++;
            $display("FAIL areset_result got %h want 0", result);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 1'b0, res, lat, tmo);
        n_checks++;
        if (tmo || res !== 64'h4008000000000000 || lat != 4) begin
            n_errors++;
            $display("FAIL after_reset got %h lat %0d want 4008000000000000 lat 4", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, exp_r, res;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 8; i++) begin
            a     = mk(1'b0, $urandom_range(1010, 1030), rfrac());
            b     = mk(1'b0, $urandom_range(1010, 1030), rfrac());
            exp_r = model(a, b);
            do_op(a, b, 1'b0, 1'b0, res, lat, tmo);
            n_checks++;
            if (tmo || res !== exp_r || lat != 4) begin
                n_errors++;
                $display("FAIL b2b%0d got %h lat %0d want %h lat 4", i, res, lat, exp_r);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b%0d_idle in_ready %b out_valid %b want 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] spec_tbl [8];
        logic [63:0] a, b, b_eff, exp_r, res;
        logic        opv, spc;
        int          lat, ea, eb, d, mode, exp_lat;
        bit          tmo;
        spec_tbl = '{64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000,
                     64'hFFF0000000000001, 64'h0000000000000000, 64'h8000000000000000,
                     64'h0000000000000123, 64'h800FFFFFFFFFFFFF};
        for (int i = 0; i < 200; i++) begin
            mode = $urandom_range(0, 6);
            ea   = $urandom_range(1000, 1046);
            a    = mk(1'($urandom_range(0, 1)), ea, rfrac());
            case (mode)
                0: b = mk(1'($urandom_range(0, 1)), $urandom_range(1000, 1046), rfrac());
                1: b = mk(~a[63], ea + $urandom_range(0, 2) - 1, rfrac());
                2: b = {~a[63], a[62:0] ^ 63'($urandom_range(0, 15))};
                3: b = mk(1'($urandom_range(0, 1)), ea - $urandom_range(50, 70), rfrac());
                4: begin
                    a = spec_tbl[$urandom_range(0, 7)];
                    if ($urandom_range(0, 1) == 1) b = spec_tbl[$urandom_range(0, 7)];
                    else b = mk(1'($urandom_range(0, 1)), ea, rfrac());
                end
                5: begin
                    a = mk(1'($urandom_range(0, 1)), $urandom_range(2040, 2046), rfrac());
                    b = mk(a[63], $urandom_range(2040, 2046), rfrac());
                end
                default: begin
                    a = mk(1'($urandom_range(0, 1)), $urandom_range(1, 4), rfrac());
                    b = mk(~a[63], $urandom_range(1, 4), rfrac());
                end
            endcase
`ifdef FP_SUB_EN
            opv = 1'($urandom_range(0, 1));
`else
            opv = 1'b0;
`endif
            b_eff = {b[63] ^ opv, b[62:0]};
            exp_r = model(a, b_eff);
            ea    = int'(a[62:52]);
            eb    = int'(b_eff[62:52]);
            d     = (ea > eb) ? ea - eb : eb - ea;
            spc   = (ea == 0) || (eb == 0) || (ea == 2047) || (eb == 2047);
            if (spc) exp_lat = 1;
            else if (a[63] == b_eff[63] || d >= 2) exp_lat = 4;
            else exp_lat = -1;
            do_op(a, b, opv, 1'b0, res, lat, tmo);
            n_checks++;
            if (tmo || res !== exp_r) begin
                n_errors++;
                $display("FAIL rand%0d a %h b %h op %0d got %h want %h timeout=%0d",
                         i, a, b, opv, res, exp_r, tmo);
            end
            if (exp_lat > 0) begin
                n_checks++;
                if (lat != exp_lat) begin
                    n_errors++;
                    $display("FAIL rand%0d_latency a %h b %h got %0d want %0d", i, a, b, lat, exp_lat);
                end
            end
        end
    endtask

`ifdef FP_SUB_EN
    task automatic test_sub();
        logic [63:0] xa [4];
        logic [63:0] xb [4];
        logic [63:0] xe [4];
        logic [63:0] res;
        int          lat;
        bit          tmo;
        xa = '{64'h4008000000000000, 64'h7FF0000000000000, 64'h3FF0000000000000, 64'h8000000000000000};
        xb = '{64'h3FF0000000000000, 64'h7FF0000000000000, 64'h0000000000000000, 64'h0000000000000000};
        xe = '{64'h4000000000000000, QNAN, 64'h3FF0000000000000, 64'h8000000000000000};
        for (int i = 0; i < 4; i++) begin
            do_op(xa[i], xb[i], 1'b1, 1'b0, res, lat, tmo);
            n_checks++;
            if (tmo || res !== xe[i]) begin
                n_errors++;
                $display("FAIL sub%0d got %h want %h timeout=%0d", i, res, xe[i], tmo);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_specials();
        test_async_reset();
        test_back_to_back();
        test_random();
`ifdef FP_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
